// File: rtl/cp0_ctrl.sv
// Co-processor 0 for the 5-stage MIPS pipeline: SR/CAUSE/EPC/EHBR, MFC0/MTC0, interrupt entry and ERET redirect.
// Optional COUNT/COMPARE timer (IP7) enabled by defining CP0_TIMER_EN.
module cp0_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_000C,
    parameter int          IRQ_SYNC     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [1:0]  oper,
    input  logic [4:0]  addr_cpr,
    input  logic [31:0] data_w_cpr,
    output logic [31:0] data_r_cpr,
    input  logic [31:0] ret_addr,
    input  logic        irq,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        in_isr
);
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_SR      = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_EHBR    = 5'd15;

    typedef enum logic [1:0] {IDLE, ISR, GUARD} state_t;

    state_t              state;
    logic                ie, pie, ip0, ip7;
    logic [7:0]          im;
    logic [31:0]         epc, ehbr;
    logic [IRQ_SYNC-1:0] sync;
    logic                irq_prev;

    logic mtc0, eret, op_none, irq_rise, take_int;
    logic [31:0] sr_val, cause_val;

    assign mtc0     = id_valid && (oper == 2'd1);
    assign eret     = id_valid && (oper == 2'd2);
    assign op_none  = (oper == 2'd0) || (oper == 2'd3);
    assign irq_rise = sync[IRQ_SYNC-1] && !irq_prev;

    assign sr_val    = {16'h0, im, 6'h0, pie, ie};
    assign cause_val = {16'h0, ip7, 6'h0, ip0, 8'h0};
    assign take_int  = ie && (|({ip7, 6'h0, ip0} & im)) && id_valid && op_none && (state == IDLE);

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;
    logic        timer_hit;
    assign timer_hit = (count == compare) && (compare != 32'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 32'h0;
            compare <= 32'h0;
            ip7     <= 1'b0;
        end else begin
            count <= (mtc0 && addr_cpr == A_COUNT) ? data_w_cpr : count + 32'd1;
            if (mtc0 && addr_cpr == A_COMPARE)
                compare <= data_w_cpr;
            // A match in the same cycle as a COMPARE write still latches IP7
            if (timer_hit)
                ip7 <= 1'b1;
            else if (mtc0 && addr_cpr == A_COMPARE)
                ip7 <= 1'b0;
            else if (mtc0 && addr_cpr == A_CAUSE)
                ip7 <= data_w_cpr[15];
        end
    end
`else
    assign ip7 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            irq_prev <= 1'b0;
            ip0      <= 1'b0;
        end else begin
            sync     <= {sync[IRQ_SYNC-2:0], irq};
            irq_prev <= sync[IRQ_SYNC-1];
            if (irq_rise)
                ip0 <= 1'b1;
            else if (mtc0 && addr_cpr == A_CAUSE)
                ip0 <= data_w_cpr[8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ie    <= 1'b0;
            pie   <= 1'b0;
            im    <= 8'h0;
            epc   <= 32'h0;
            ehbr  <= HANDLER_ADDR;
        end else begin
            if (mtc0 && addr_cpr == A_SR) begin
                ie  <= data_w_cpr[0];
                pie <= data_w_cpr[1];
                im  <= data_w_cpr[15:8];
            end
            if (mtc0 && addr_cpr == A_EPC)
                epc <= data_w_cpr;
            if (mtc0 && addr_cpr == A_EHBR)
                ehbr <= data_w_cpr;
            // ERET restores IE and consumes the saved copy so SR returns to its pre-entry value
            if (eret) begin
                ie    <= pie;
                pie   <= 1'b0;
                state <= GUARD;
            end else if (take_int) begin
                epc   <= ret_addr;
                pie   <= ie;
                ie    <= 1'b0;
                state <= ISR;
            end else if (state == GUARD) begin
                state <= IDLE;
            end
        end
    end

    always_comb begin
        data_r_cpr = 32'h0;
        if (mtc0) begin
            data_r_cpr = data_w_cpr;
        end else begin
            case (addr_cpr)
`ifdef CP0_TIMER_EN
                A_COUNT:   data_r_cpr = count;
                A_COMPARE: data_r_cpr = compare;
`endif
                A_SR:      data_r_cpr = sr_val;
                A_CAUSE:   data_r_cpr = cause_val;
                A_EPC:     data_r_cpr = epc;
                A_EHBR:    data_r_cpr = ehbr;
                default:   data_r_cpr = 32'h0;
            endcase
        end
    end

    always_comb begin
        jump_en   = rst_n && (eret || take_int);
        jump_addr = 32'h0;
        if (rst_n && eret)
            jump_addr = epc;
        else if (rst_n && take_int)
            jump_addr = ehbr;
    end

    assign in_isr = (state == ISR);
endmodule

// File: tb/tb_cp0_ctrl.sv
// Randomized + directed bench for cp0_ctrl against a field-level behavioural model of CP0.
module tb_cp0_ctrl;
    localparam int IRQ_SYNC = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, irq = 1'b0;
    logic [1:0]  oper = 2'd0;
    logic [4:0]  addr_cpr = 5'd0;
    logic [31:0] data_w_cpr = 32'h0, ret_addr = 32'h0;
    logic [31:0] data_r_cpr, jump_addr;
    logic        jump_en, in_isr;

    cp0_ctrl #(.HANDLER_ADDR(32'h0000_000C), .IRQ_SYNC(IRQ_SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .oper(oper), .addr_cpr(addr_cpr),
        .data_w_cpr(data_w_cpr), .data_r_cpr(data_r_cpr), .ret_addr(ret_addr), .irq(irq),
        .jump_en(jump_en), .jump_addr(jump_addr), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // model state: individual fields, mode 0=idle 1=handler 2=guard
    bit        m_ie, m_pie, m_ip0, m_ip7;
    bit [7:0]  m_im;
    bit [31:0] m_epc, m_ehbr, m_count, m_compare;
    int        m_mode;
    bit        irq_hist[$];

    task automatic model_reset();
        m_ie = 0; m_pie = 0; m_ip0 = 0; m_ip7 = 0; m_im = 0;
        m_epc = 0; m_ehbr = 32'hC; m_count = 0; m_compare = 0; m_mode = 0;
        irq_hist = {};
        for (int i = 0; i <= IRQ_SYNC; i++) irq_hist.push_back(1'b0);
    endtask

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        case (a)
            5'd9:  return TIMER ? m_count : 32'h0;
            5'd11: return TIMER ? m_compare : 32'h0;
            5'd12: return {16'h0, m_im, 6'h0, m_pie, m_ie};
            5'd13: return {16'h0, m_ip7, 6'h0, m_ip0, 8'h0};
            5'd14: return m_epc;
            5'd15: return m_ehbr;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_eret();
        return rst_n && id_valid && oper == 2'd2;
    endfunction

    function automatic bit m_take();
        return rst_n && m_ie && ((m_im[0] && m_ip0) || (m_im[7] && m_ip7)) && id_valid &&
               (oper == 2'd0 || oper == 2'd3) && m_mode == 0;
    endfunction

    task automatic model_clock();
        bit wr, er, tk, rise, hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wr   = id_valid && oper == 2'd1;
        er   = m_eret();
        tk   = m_take();
        rise = irq_hist[IRQ_SYNC-1] && !irq_hist[IRQ_SYNC];
        hit  = TIMER && m_count == m_compare && m_compare != 0;
        if (er) begin
            m_ie = m_pie; m_pie = 0; m_mode = 2;
        end else if (tk) begin
            m_epc = ret_addr; m_pie = m_ie; m_ie = 0; m_mode = 1;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end
        if (TIMER && !(wr && addr_cpr == 5'd9)) m_count = m_count + 1;
        if (wr) begin
            case (addr_cpr)
                5'd9:  if (TIMER) m_count = data_w_cpr;
                5'd11: if (TIMER) begin m_compare = data_w_cpr; m_ip7 = 0; end
                5'd12: begin m_ie = data_w_cpr[0]; m_pie = data_w_cpr[1]; m_im = data_w_cpr[15:8]; end
                5'd13: begin m_ip0 = data_w_cpr[8]; m_ip7 = TIMER && data_w_cpr[15]; end
                5'd14: m_epc = data_w_cpr;
                5'd15: m_ehbr = data_w_cpr;
                default: ;
            endcase
        end
        if (rise) m_ip0 = 1;
        if (hit) m_ip7 = 1;
        irq_hist.push_front(irq);
        void'(irq_hist.pop_back());
    endtask

    task automatic compare_outputs();
        bit je;
        je = m_eret() || m_take();
        check("rd", data_r_cpr, (id_valid && oper == 2'd1) ? data_w_cpr : m_reg(addr_cpr));
        check("jump_en", {31'h0, jump_en}, {31'h0, je});
        if (je) check("jump_addr", jump_addr, m_eret() ? m_epc : m_ehbr);
        check("in_isr", {31'h0, in_isr}, {31'h0, (m_mode == 1)});
    endtask

    // advance one cycle, drive new inputs mid-cycle, check combinational outputs
    task automatic step(input bit v, input logic [1:0] op, input logic [4:0] a,
                        input logic [31:0] wd, input logic [31:0] ra, input bit iq);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        id_valid = v; oper = op; addr_cpr = a; data_w_cpr = wd; ret_addr = ra; irq = iq;
        #1;
        compare_outputs();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_jump_en", {31'h0, jump_en}, 32'h0);
        check("arst_in_isr", {31'h0, in_isr}, 32'h0);
        check("arst_rd", data_r_cpr, (id_valid && oper == 2'd1) ? data_w_cpr : m_reg(addr_cpr));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [4:0] addr_pool [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd20};

    initial begin
        bit seen;
        int r;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 2'd2, 5'd14, 32'h0, 32'h0, 0);
            check("rst_jump_en", {31'h0, jump_en}, 32'h0);
        end
        @(negedge clk) rst_n = 1'b1;

        step(0, 2'd0, 5'd12, 0, 0, 0); check("rst_sr", data_r_cpr, 32'h0);
        step(0, 2'd0, 5'd13, 0, 0, 0); check("rst_cause", data_r_cpr, 32'h0);
        step(0, 2'd0, 5'd14, 0, 0, 0); check("rst_epc", data_r_cpr, 32'h0);
        step(0, 2'd0, 5'd15, 0, 0, 0); check("rst_ehbr", data_r_cpr, 32'hC);

        // interrupt entry
        step(1, 2'd1, 5'd12, 32'h101, 0, 0);
        step(0, 2'd0, 5'd13, 0, 0, 1);
        step(0, 2'd0, 5'd13, 0, 0, 0);
        step(0, 2'd0, 5'd13, 0, 0, 0);
        step(0, 2'd0, 5'd13, 0, 0, 0); check("ip0_set", data_r_cpr, 32'h100);
        step(1, 2'd0, 5'd0, 0, 32'h40, 0);
        check("entry_jump", {31'h0, jump_en}, 32'h1); check("entry_addr", jump_addr, 32'hC);
        step(0, 2'd0, 5'd14, 0, 0, 0);
        check("entry_once", {31'h0, jump_en}, 32'h0); check("entry_epc", data_r_cpr, 32'h40);
        check("entry_isr", {31'h0, in_isr}, 32'h1);
        step(0, 2'd0, 5'd12, 0, 0, 0); check("entry_sr", data_r_cpr, 32'h102);

        // no nesting; clear then re-pend IP0; ERET; guard cycle blocks
        step(1, 2'd0, 5'd12, 0, 32'h80, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 2'd0, 5'd13, 0, 32'h80, 0);
            check("isr_blocked", {31'h0, jump_en}, 32'h0);
        end
        step(1, 2'd1, 5'd13, 32'h0, 0, 0);
        step(0, 2'd0, 5'd13, 0, 0, 0); check("ip0_clr", data_r_cpr, 32'h0);
        step(0, 2'd0, 5'd13, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 2'd0, 5'd13, 0, 0, 0);
        step(1, 2'd2, 5'd12, 0, 0, 0);
        check("eret_jump", {31'h0, jump_en}, 32'h1); check("eret_addr", jump_addr, 32'h40);
        step(1, 2'd0, 5'd12, 0, 32'h44, 0);
        check("guard_block", {31'h0, jump_en}, 32'h0); check("eret_sr", data_r_cpr, 32'h101);
        // pending IP0 held off by MTC0, then taken
        step(1, 2'd1, 5'd15, 32'hC, 32'h48, 0);
        check("mtc0_block", {31'h0, jump_en}, 32'h0);
        step(1, 2'd0, 5'd0, 0, 32'h4C, 0);
        check("late_entry", {31'h0, jump_en}, 32'h1);
        step(1, 2'd2, 5'd0, 0, 0, 0); check("eret2_addr", jump_addr, 32'h4C);
        step(1, 2'd1, 5'd13, 32'h0, 0, 0);
        // EPC write then immediate ERET; same-cycle bypass
        step(1, 2'd1, 5'd14, 32'h100, 0, 0); check("bypass", data_r_cpr, 32'h100);
        step(1, 2'd2, 5'd0, 0, 0, 0);
        check("eret_new_epc", {31'h0, jump_en}, 32'h1); check("eret_new_addr", jump_addr, 32'h100);
        step(0, 2'd0, 5'd0, 0, 0, 0);

`ifdef CP0_TIMER_EN
        step(1, 2'd1, 5'd13, 32'h0, 0, 0);
        step(1, 2'd1, 5'd11, 32'd20, 0, 0);
        step(1, 2'd1, 5'd9, 32'd10, 0, 0);
        step(1, 2'd1, 5'd12, 32'h8001, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 2'd0, 5'd13, 0, 32'h200, 0);
            seen = jump_en;
        end
        check("timer_entry", {31'h0, seen}, 32'h1);
        step(1, 2'd1, 5'd11, 32'd20, 0, 0);
        step(0, 2'd0, 5'd13, 0, 0, 0); check("ip7_clr", data_r_cpr, 32'h0);
        async_reset();
        step(0, 2'd0, 5'd12, 0, 0, 0); check("timer_rst_sr", data_r_cpr, 32'h0);
`endif

        // software-pended interrupt, then reset while in the handler
        step(1, 2'd1, 5'd13, 32'h100, 0, 0);
        step(1, 2'd1, 5'd12, 32'h101, 0, 0);
        step(1, 2'd0, 5'd0, 0, 32'h300, 0);
        step(0, 2'd0, 5'd12, 0, 0, 0); check("pre_rst_isr", {31'h0, in_isr}, 32'h1);
        async_reset();
        step(0, 2'd0, 5'd12, 0, 0, 0); check("post_rst_sr", data_r_cpr, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [1:0] op;
            r = $urandom_range(0, 9);
            op = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r == 7) ? 2'd2 : (r == 8) ? 2'd3 : 2'd0;
            step($urandom_range(0, 4) != 0, op, addr_pool[$urandom_range(0, 7)],
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 $urandom, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
